dlx_mem_arbiter: RTL

- Shares one single-ported unified memory between the DLX instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Runs an IDLE/BUSY FSM with data-over-instruction priority and an anti-starvation streak limit.
- Provides a response watchdog that aborts hung transactions.
- Generates the per-requester valid and stall signals the pipeline uses to freeze stages.

---
 rtl/dlx_mem_pkg.sv | 33 +++
 rtl/dlx_mem_arbiter_if.sv | 45 ++++
 rtl/dlx_mem_watchdog.sv | 34 +++
 rtl/dlx_mem_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/dlx_mem_pkg.sv
// Shared arbiter state/grant types, the rdata value returned on an aborted
// transaction, and the IDLE-state arbitration rule.
package dlx_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_I_BUSY = 2'd1,
    ARB_D_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } grant_t;

  localparam int unsigned ERR_RDATA_W = 64;
  localparam logic [ERR_RDATA_W-1:0] ERR_RDATA = '0;

  // Data wins unless it has already taken its full streak while fetch waits.
  function automatic grant_t arb_pick(input logic i_req, input logic d_req,
                                      input logic streak_full);
    grant_t g;
    g = GNT_NONE;
    if (d_req && !(i_req && streak_full)) begin
      g = GNT_D;
    end else if (i_req) begin
      g = GNT_I;
    end
    return g;
  endfunction

endpackage

// File: rtl/dlx_mem_arbiter_if.sv
// Bundle of the IF requester, MEM requester, memory port and pipeline stall
// signals; master is the arbiter side, slave the surrounding pipeline/memory.
interface dlx_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_valid;

  logic              stall_if;
  logic              stall_mem;
  logic              err;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_valid,
    output i_rdata, i_valid, d_rdata, d_valid,
    output m_req, m_we, m_addr, m_wdata,
    output stall_if, stall_mem, err
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_valid,
    input  i_rdata, i_valid, d_rdata, d_valid,
    input  m_req, m_we, m_addr, m_wdata,
    input  stall_if, stall_mem, err
  );

endinterface

// File: rtl/dlx_mem_watchdog.sv
// Counts BUSY cycles without a memory completion; timeout is a combinational
// pulse on the TIMEOUT-th such cycle. TIMEOUT=0 disables it.
module dlx_mem_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_busy,
  input  logic i_done,
  output logic o_timeout
);

  localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_hung;

  assign w_hung    = i_busy && !i_done && (r_cnt == CNT_LAST);
  assign o_timeout = (TIMEOUT != 0) && w_hung;

  // Saturates at the last count; the next grant clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_busy && !i_done && (r_cnt != CNT_LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dlx_mem_arbiter.sv
// Arbitrates one single-ported memory between DLX fetch and data stages, with
// a data-first streak limit, a response watchdog and pipeline stall outputs.
module dlx_mem_arbiter
  import dlx_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input logic                clk,
  input logic                reset,
  dlx_mem_arbiter_if.master  bus
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  grant_t              w_grant;
  logic [STREAK_W-1:0] r_streak;
  logic                w_streak_full;
  logic                r_m_we;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic                r_err;
  logic                w_busy;
  logic                w_timeout;
  logic                w_fin;
  logic                w_i_valid;
  logic                w_d_valid;

  assign w_busy        = (r_state != ARB_IDLE);
  assign w_streak_full = (r_streak == STREAK_MAX);
  assign w_grant       = (r_state == ARB_IDLE) ?
                         arb_pick(bus.i_req, bus.d_req, w_streak_full) : GNT_NONE;
  assign w_fin         = bus.m_valid | w_timeout;

  dlx_mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_grant != GNT_NONE),
    .i_busy    (w_busy),
    .i_done    (bus.m_valid),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Every BUSY period returns through IDLE, so a req still high in its
  // completion cycle cannot be granted twice.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        case (w_grant)
          GNT_I:   w_state_nxt = ARB_I_BUSY;
          GNT_D:   w_state_nxt = ARB_D_BUSY;
          default: w_state_nxt = ARB_IDLE;
        endcase
      end
      ARB_I_BUSY, ARB_D_BUSY: begin
        if (w_fin) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    w_i_valid     = (r_state == ARB_I_BUSY) && w_fin;
    w_d_valid     = (r_state == ARB_D_BUSY) && w_fin;
    bus.m_req     = w_busy;
    bus.m_we      = r_m_we;
    bus.m_addr    = r_m_addr;
    bus.m_wdata   = r_m_wdata;
    bus.i_valid   = w_i_valid;
    bus.d_valid   = w_d_valid;
    bus.i_rdata   = ((r_state == ARB_I_BUSY) && bus.m_valid) ? bus.m_rdata : DATA_W'(ERR_RDATA);
    bus.d_rdata   = ((r_state == ARB_D_BUSY) && bus.m_valid) ? bus.m_rdata : DATA_W'(ERR_RDATA);
    bus.stall_if  = bus.i_req & ~w_i_valid;
    bus.stall_mem = bus.d_req & ~w_d_valid;
    bus.err       = r_err;
  end

  // Request fields are captured once at grant and held for the BUSY period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_streak  <= '0;
      r_err     <= 1'b0;
    end else begin
      case (w_grant)
        GNT_I: begin
          r_m_addr  <= bus.i_addr;
          r_m_we    <= 1'b0;
          r_m_wdata <= '0;
          r_streak  <= '0;
        end
        GNT_D: begin
          r_m_addr  <= bus.d_addr;
          r_m_we    <= bus.d_we;
          r_m_wdata <= bus.d_wdata;
          if (!bus.i_req) begin
            r_streak <= '0;
          end else if (!w_streak_full) begin
            r_streak <= r_streak + 1'b1;
          end
        end
        default: ;
      endcase
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
